// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one word-fetch in flight at a time, pushes results into the
// instruction queue and redirects on ROB/CDB refresh, squashing any fetch already issued.
module fetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  refresh_rob_cdb_in,
  input  logic [ADDR_WIDTH-1:0] pc_rob_cdb_in,
  input  logic                  iq_full_iq_in,
  output logic [INST_WIDTH-1:0] inst_iq_out,
  output logic [ADDR_WIDTH-1:0] pc_iq_out,
  output logic                  rdy_inst_iq_out,
  output logic                  req_mem_out,
  output logic [ADDR_WIDTH-1:0] addr_mem_out,
  input  logic [INST_WIDTH-1:0] inst_mem_in,
  input  logic                  done_mem_in
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  squash_q, squash_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  push_q, push_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    req_d    = req_q;
    addr_d   = addr_q;
    push_d   = 1'b0;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    case (state_q)
      StIdle: begin
        if (refresh_rob_cdb_in) begin
          pc_d = pc_rob_cdb_in;
        end else if (!iq_full_iq_in) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (done_mem_in) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          state_d  = StIdle;
          if (refresh_rob_cdb_in) begin
            pc_d = pc_rob_cdb_in;
          end else if (!squash_q) begin
            push_d   = 1'b1;
            inst_d   = inst_mem_in;
            pc_out_d = addr_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
          end
        end else if (refresh_rob_cdb_in) begin
          // Memory transaction cannot be cancelled; remember to drop its word.
          pc_d     = pc_rob_cdb_in;
          squash_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      push_q   <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      push_q   <= push_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign inst_iq_out     = inst_q;
  assign pc_iq_out       = pc_out_q;
  assign rdy_inst_iq_out = push_q;
  assign req_mem_out     = req_q;
  assign addr_mem_out    = addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random stimulus against a
// transaction-level reference model of the fetch sequencer.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        refresh = 1'b0;
  logic [31:0] tgt = '0;
  logic        full = 1'b0;
  logic [31:0] inst_mem = '0;
  logic        done = 1'b0;
  logic [31:0] inst_iq;
  logic [31:0] pc_iq;
  logic        push;
  logic        req;
  logic [31:0] addr;

  fetch_ctrl #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h0)
  ) u_dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .rdy_in            (rdy),
    .refresh_rob_cdb_in(refresh),
    .pc_rob_cdb_in     (tgt),
    .iq_full_iq_in     (full),
    .inst_iq_out       (inst_iq),
    .pc_iq_out         (pc_iq),
    .rdy_inst_iq_out   (push),
    .req_mem_out       (req),
    .addr_mem_out      (addr),
    .inst_mem_in       (inst_mem),
    .done_mem_in       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model
  int unsigned mem_lat   = 1;
  int unsigned wait_cnt  = 0;
  bit          mem_const = 1'b0;

  // Reference model state
  logic [31:0] m_pc, m_addr, m_inst, m_pcout;
  bit          m_busy, m_cancel, m_push;

  // Event logs
  logic [31:0] req_log[$];
  logic [31:0] push_pc_log[$];
  logic [31:0] push_inst_log[$];
  bit          prev_req  = 1'b0;
  bit          prev_push = 1'b0;
  int          double_pulse = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_const) return 32'h0000_0013;
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    push_pc_log.delete();
    push_inst_log.delete();
  endtask

  // One clock: drive inputs, clock edge, advance the model, sample outputs #1 later.
  task automatic step(input logic s_rst, input logic s_rdy, input logic s_ref,
                      input logic [31:0] s_tgt, input logic s_full);
    if (req !== 1'b1) wait_cnt = 0;
    done     = (req === 1'b1) && (wait_cnt + 1 >= mem_lat);
    inst_mem = done ? mem_word(addr) : $urandom();
    if (s_rdy && req === 1'b1) wait_cnt++;
    rst = s_rst; rdy = s_rdy; refresh = s_ref; tgt = s_tgt; full = s_full;
    @(posedge clk);
    if (s_rst) begin
      m_pc = 32'h0; m_busy = 0; m_cancel = 0; m_push = 0;
      m_addr = '0; m_inst = '0; m_pcout = '0;
    end else if (s_rdy) begin
      m_push = 0;
      if (!m_busy) begin
        if (s_ref) m_pc = s_tgt;
        else if (!s_full) begin
          m_busy = 1; m_addr = m_pc;
        end
      end else if (done) begin
        m_busy = 0;
        if (!s_ref && !m_cancel) begin
          m_push = 1; m_inst = inst_mem; m_pcout = m_addr; m_pc = m_pc + 32'd4;
        end
        if (s_ref) m_pc = s_tgt;
        m_cancel = 0;
      end else if (s_ref) begin
        m_pc = s_tgt; m_cancel = 1;
      end
    end
    #1;
    if (req === 1'b1 && !prev_req) req_log.push_back(addr);
    if (push === 1'b1 && s_rdy && !s_rst) begin
      push_pc_log.push_back(pc_iq);
      push_inst_log.push_back(inst_iq);
      if (prev_push) double_pulse++;
    end
    prev_req  = (req === 1'b1);
    prev_push = (push === 1'b1);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    clear_logs();
    double_pulse = 0;
  endtask

  task automatic test_reset();
    mem_const = 1'b0;
    do_reset();
    n_checks++;
    if (req !== 1'b0) begin n_errors++; $display("FAIL reset_req got=%b want=0", req); end
    n_checks++;
    if (addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got=%h want=0", addr); end
    n_checks++;
    if (push !== 1'b0) begin n_errors++; $display("FAIL reset_push got=%b want=0", push); end
    n_checks++;
    if (inst_iq !== 32'h0 || pc_iq !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_iq got inst=%h pc=%h want 0/0", inst_iq, pc_iq);
    end
  endtask

  task automatic test_basic_fetch();
    mem_const = 1'b1;
    mem_lat   = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    n_checks++;
    if (req_log.size() != 3 || push_pc_log.size() != 3) begin
      n_errors++;
      $display("FAIL basic_counts got req=%0d push=%0d want 3/3", req_log.size(),
               push_pc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (req_log[i] !== 32'(i * 4) || push_pc_log[i] !== 32'(i * 4) ||
            push_inst_log[i] !== 32'h13) begin
          n_errors++;
          $display("FAIL basic_fetch%0d got req=%h pc=%h inst=%h want %h/%h/00000013", i,
                   req_log[i], push_pc_log[i], push_inst_log[i], i * 4, i * 4);
        end
      end
    end
    n_checks++;
    if (double_pulse != 0) begin
      n_errors++; $display("FAIL basic_pulse_width got=%0d wide pulses want=0", double_pulse);
    end
    mem_const = 1'b0;
  endtask

  task automatic test_full();
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1);
      n_checks++;
      if (req !== 1'b0) begin n_errors++; $display("FAIL full_hold%0d got req=%b want=0", i, req); end
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_errors++; $display("FAIL full_release got req=%b addr=%h want 1/0", req, addr);
    end
  endtask

  task automatic test_refresh_wait();
    bit found = 0;
    mem_lat = 4;
    do_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 0, 0, 0);
      found = (req === 1'b1 && addr === 32'h8);
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL refresh_wait_timeout got no request to 8 want request");
    end else begin
      clear_logs();
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'h100, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
      n_checks++;
      if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
        n_errors++;
        $display("FAIL refresh_wait_req got=%h want=00000100",
                 req_log.size() ? req_log[0] : 32'hx);
      end
      n_checks++;
      if (push_pc_log.size() == 0 || push_pc_log[0] !== 32'h100 ||
          push_inst_log[0] !== mem_word(32'h100)) begin
        n_errors++;
        $display("FAIL refresh_wait_push got pc=%h want pc=00000100 inst=%h",
                 push_pc_log.size() ? push_pc_log[0] : 32'hx, mem_word(32'h100));
      end
    end
  endtask

  task automatic test_refresh_done();
    bit found = 0;
    bit saw4  = 0;
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 1, 0, 0, 0);
      found = (req === 1'b1 && addr === 32'h4);
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL refresh_done_timeout got no request to 4 want request");
    end else begin
      clear_logs();
      step(0, 1, 1, 32'h200, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
      foreach (push_pc_log[i]) if (push_pc_log[i] === 32'h4) saw4 = 1;
      n_checks++;
      if (saw4) begin n_errors++; $display("FAIL refresh_done_drop got push of 4 want none"); end
      n_checks++;
      if (req_log.size() == 0 || req_log[0] !== 32'h200) begin
        n_errors++;
        $display("FAIL refresh_done_req got=%h want=00000200",
                 req_log.size() ? req_log[0] : 32'hx);
      end
    end
  endtask

  task automatic test_stall();
    int pushes0 = 0;
    mem_lat = 2;
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (req !== 1'b1 || addr !== 32'h0 || push !== 1'b0 || done !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_freeze%0d got req=%b addr=%h push=%b done=%b want 1/0/0/1", i, req,
                 addr, push, done);
      end
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (push !== 1'b1 || pc_iq !== 32'h0 || inst_iq !== mem_word(32'h0)) begin
      n_errors++;
      $display("FAIL stall_push got push=%b pc=%h inst=%h want 1/0/%h", push, pc_iq, inst_iq,
               mem_word(32'h0));
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    foreach (push_pc_log[i]) if (push_pc_log[i] === 32'h0) pushes0++;
    n_checks++;
    if (pushes0 != 1) begin
      n_errors++; $display("FAIL stall_once got=%0d pushes of 0 want=1", pushes0);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit found = 0;
    mem_lat = 1;
    do_reset();
    step(0, 1, 1, 32'hFFFF_FFFC, 0);
    clear_logs();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    n_checks++;
    if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_req got n=%0d first=%h second=%h want fffffffc/00000000",
               req_log.size(), req_log.size() ? req_log[0] : 32'hx,
               req_log.size() > 1 ? req_log[1] : 32'hx);
    end
    n_checks++;
    if (push_pc_log.size() == 0 || push_pc_log[0] !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_push got=%h want=fffffffc",
               push_pc_log.size() ? push_pc_log[0] : 32'hx);
    end
    mem_lat = 4;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 1, 0, 0, 0);
      found = (req === 1'b1);
    end
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (req !== 1'b0 || addr !== 32'h0) begin
      n_errors++; $display("FAIL midwait_reset got req=%b addr=%h want 0/0", req, addr);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_pc got req=%b addr=%h want 1/00000000", req, addr);
    end
  endtask

  task automatic test_random();
    logic        r_rst, r_rdy, r_ref, r_full;
    logic [31:0] r_tgt;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (req !== 1'b1) mem_lat = $urandom_range(1, 4);
      r_rst  = ($urandom_range(0, 99) < 1);
      r_rdy  = ($urandom_range(0, 9) != 0);
      r_ref  = ($urandom_range(0, 9) == 0);
      r_full = ($urandom_range(0, 9) < 3);
      r_tgt  = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 4095), 2'b00};
      step(r_rst, r_rdy, r_ref, r_tgt, r_full);
      n_checks++;
      if (req !== m_busy || addr !== m_addr) begin
        n_errors++;
        $display("FAIL rand_req c=%0d got req=%b addr=%h want %b/%h", c, req, addr, m_busy,
                 m_addr);
      end
      n_checks++;
      if (push !== m_push || pc_iq !== m_pcout || inst_iq !== m_inst) begin
        n_errors++;
        $display("FAIL rand_push c=%0d got push=%b pc=%h inst=%h want %b/%h/%h", c, push,
                 pc_iq, inst_iq, m_push, m_pcout, m_inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_full();
    test_refresh_wait();
    test_refresh_done();
    test_stall();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
